// File: rtl/ovl_motion_sched.sv
// Raster position tracker plus per-frame bounce scheduler for a bank of overlay objects.
// Optional build macro OVL_SCHED_FRAME_DIV_EN: run the bounce update only every FRAME_DIV-th vblank.
module ovl_motion_sched #(
  parameter int unsigned N_OBJ     = 2,
  parameter int unsigned OBJ_W     = 320,
  parameter int unsigned OBJ_H     = 320,
  parameter int unsigned SCREEN_W  = 1920,
  parameter int unsigned SCREEN_H  = 1080,
  parameter int unsigned STEP      = 5,
  parameter int unsigned FRAME_DIV = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cen_i,
  input  logic [1:0]            vh_blank_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [2:0]            cmd_idx_i,
  input  logic [11:0]           cmd_x_i,
  input  logic [11:0]           cmd_y_i,
  input  logic [1:0]            cmd_dir_i,
  output logic [11:0]           hcount_o,
  output logic [11:0]           vcount_o,
  output logic [12*N_OBJ-1:0]   obj_x_o,
  output logic [12*N_OBJ-1:0]   obj_y_o,
  output logic                  busy_o,
  output logic                  update_done_o,
  output logic [15:0]           frame_cnt_o
);

  // Handshake: a command transfers on any clk_i edge where cmd_valid_i and
  // cmd_ready_o are both high; ready is high only while the scheduler is idle.

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_t;

  localparam logic [11:0] LIM_X = 12'(SCREEN_W - OBJ_W);
  localparam logic [11:0] LIM_Y = 12'(SCREEN_H - OBJ_H);
  localparam logic [2:0]  LAST  = 3'(N_OBJ - 1);

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [1:0]  blank_q;
  logic [11:0] hcount_q, vcount_q;
  logic [15:0] frame_q;
  logic [11:0] x_q [N_OBJ];
  logic [11:0] x_d [N_OBJ];
  logic [11:0] y_q [N_OBJ];
  logic [11:0] y_d [N_OBJ];
  logic        dx_q [N_OBJ];
  logic        dx_d [N_OBJ];
  logic        dy_q [N_OBJ];
  logic        dy_d [N_OBJ];
  logic        hrise, hfall, vrise, upd_start, cmd_fire;

  assign hrise = cen_i &  vh_blank_i[0] & ~blank_q[0];
  assign hfall = cen_i & ~vh_blank_i[0] &  blank_q[0];
  assign vrise = cen_i &  vh_blank_i[1] & ~blank_q[1];

`ifdef OVL_SCHED_FRAME_DIV_EN
  logic [3:0] div_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) div_q <= '0;
    else if (vrise) div_q <= (div_q == 4'(FRAME_DIV - 1)) ? 4'd0 : div_q + 4'd1;
  end
  assign upd_start = vrise & (div_q == 4'(FRAME_DIV - 1));
`else
  assign upd_start = vrise;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      blank_q  <= '0;
      hcount_q <= '0;
      vcount_q <= '0;
      frame_q  <= '0;
    end else begin
      if (cen_i) begin
        blank_q <= vh_blank_i;
        if (hfall) hcount_q <= '0;
        else if (hcount_q != 12'hFFF) hcount_q <= hcount_q + 12'd1;
      end
      if (vrise) vcount_q <= '0;
      else if (hrise && vcount_q != 12'hFFF) vcount_q <= vcount_q + 12'd1;
      if (vrise) frame_q <= frame_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: if (upd_start) begin
        state_d = S_UPDATE;
        idx_d   = '0;
      end
      S_UPDATE: begin
        if (idx_q == LAST) state_d = S_DONE;
        else idx_d = idx_q + 3'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready_o   = (state_q == S_IDLE);
  assign busy_o        = (state_q != S_IDLE);
  assign update_done_o = (state_q == S_DONE);
  assign cmd_fire      = cmd_valid_i & cmd_ready_o;

  // Returns {new_dir, new_pos}; lim is the largest legal left/top position.
  function automatic logic [12:0] bounce(input logic [11:0] pos, input logic dir,
                                         input logic [11:0] lim);
    logic [12:0] sum;
    sum = {1'b0, pos} + 13'(STEP);
    if (dir) begin
      if (sum > {1'b0, lim}) return {1'b0, lim};
      else                   return {1'b1, pos + 12'(STEP)};
    end else begin
      if ({1'b0, pos} < 13'(STEP)) return {1'b1, 12'd0};
      else                         return {1'b0, pos - 12'(STEP)};
    end
  endfunction

  always_comb begin
    logic [12:0] rx, ry;
    rx = '0;
    ry = '0;
    for (int i = 0; i < int'(N_OBJ); i++) begin
      x_d[i]  = x_q[i];
      y_d[i]  = y_q[i];
      dx_d[i] = dx_q[i];
      dy_d[i] = dy_q[i];
      // Commands land only in IDLE, so they never collide with an update slot.
      if (cmd_fire && cmd_idx_i == 3'(i)) begin
        x_d[i]  = (cmd_x_i > LIM_X) ? LIM_X : cmd_x_i;
        y_d[i]  = (cmd_y_i > LIM_Y) ? LIM_Y : cmd_y_i;
        dx_d[i] = cmd_dir_i[0];
        dy_d[i] = cmd_dir_i[1];
      end
      if (state_q == S_UPDATE && idx_q == 3'(i)) begin
        rx      = bounce(x_q[i], dx_q[i], LIM_X);
        ry      = bounce(y_q[i], dy_q[i], LIM_Y);
        x_d[i]  = rx[11:0];
        dx_d[i] = rx[12];
        y_d[i]  = ry[11:0];
        dy_d[i] = ry[12];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(N_OBJ); i++) begin
      if (rst_i) begin
        x_q[i]  <= '0;
        y_q[i]  <= '0;
        dx_q[i] <= 1'b1;
        dy_q[i] <= 1'b1;
      end else begin
        x_q[i]  <= x_d[i];
        y_q[i]  <= y_d[i];
        dx_q[i] <= dx_d[i];
        dy_q[i] <= dy_d[i];
      end
    end
  end

  always_comb begin
    obj_x_o = '0;
    obj_y_o = '0;
    for (int i = 0; i < int'(N_OBJ); i++) begin
      obj_x_o[12*i +: 12] = x_q[i];
      obj_y_o[12*i +: 12] = y_q[i];
    end
  end

  assign hcount_o    = hcount_q;
  assign vcount_o    = vcount_q;
  assign frame_cnt_o = frame_q;

endmodule

// File: tb/tb_ovl_motion_sched.sv
// Directed and randomized bench for ovl_motion_sched against a position/direction model.
module tb_ovl_motion_sched;
  localparam int N_OBJ = 2, OBJ_W = 320, OBJ_H = 320, SCREEN_W = 1920, SCREEN_H = 1080;
  localparam int STEP = 5, FRAME_DIV = 2;

  logic                clk_i = 1'b0;
  logic                rst_i, cen_i, cmd_valid_i;
  logic [1:0]          vh_blank_i, cmd_dir_i;
  logic [2:0]          cmd_idx_i;
  logic [11:0]         cmd_x_i, cmd_y_i;
  logic                cmd_ready_o, busy_o, update_done_o;
  logic [11:0]         hcount_o, vcount_o;
  logic [12*N_OBJ-1:0] obj_x_o, obj_y_o;
  logic [15:0]         frame_cnt_o;

  ovl_motion_sched dut (
    .clk_i(clk_i), .rst_i(rst_i), .cen_i(cen_i), .vh_blank_i(vh_blank_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_idx_i(cmd_idx_i),
    .cmd_x_i(cmd_x_i), .cmd_y_i(cmd_y_i), .cmd_dir_i(cmd_dir_i),
    .hcount_o(hcount_o), .vcount_o(vcount_o), .obj_x_o(obj_x_o), .obj_y_o(obj_y_o),
    .busy_o(busy_o), .update_done_o(update_done_o), .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0, checks = 0;
  int mx[N_OBJ], my[N_OBJ], mdx[N_OBJ], mdy[N_OBJ];
  int mframes, mdiv;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_OBJ; i++) begin
      mx[i] = 0; my[i] = 0; mdx[i] = 1; mdy[i] = 1;
    end
    mframes = 0;
    mdiv = 0;
  endtask

  // One axis of the bounce: moving toward the far edge stops flush with it.
  task automatic axis(inout int p, inout int d, input int sz, input int scr);
    if (d == 1) begin
      if (p + sz + STEP > scr) begin p = scr - sz; d = 0; end
      else p = p + STEP;
    end else begin
      if (p < STEP) begin p = 0; d = 1; end
      else p = p - STEP;
    end
  endtask

  task automatic model_update();
    int p, d;
    for (int i = 0; i < N_OBJ; i++) begin
      p = mx[i]; d = mdx[i]; axis(p, d, OBJ_W, SCREEN_W); mx[i] = p; mdx[i] = d;
      p = my[i]; d = mdy[i]; axis(p, d, OBJ_H, SCREEN_H); my[i] = p; mdy[i] = d;
    end
  endtask

  task automatic model_cmd(input int idx, input int x, input int y, input int dir);
    if (idx < N_OBJ) begin
      mx[idx] = (x > SCREEN_W - OBJ_W) ? SCREEN_W - OBJ_W : x;
      my[idx] = (y > SCREEN_H - OBJ_H) ? SCREEN_H - OBJ_H : y;
      mdx[idx] = dir & 1;
      mdy[idx] = (dir >> 1) & 1;
    end
  endtask

  task automatic check_objs(input string tag);
    for (int i = 0; i < N_OBJ; i++) begin
      chk($sformatf("%s_x%0d", tag, i), 32'(obj_x_o[12*i +: 12]), 32'(mx[i]));
      chk($sformatf("%s_y%0d", tag, i), 32'(obj_y_o[12*i +: 12]), 32'(my[i]));
    end
  endtask

  task automatic drive_cmd(input int idx, input int x, input int y, input int dir);
    cmd_valid_i = 1'b1;
    cmd_idx_i = 3'(idx); cmd_x_i = 12'(x); cmd_y_i = 12'(y); cmd_dir_i = 2'(dir);
  endtask

  task automatic send_cmd(input int idx, input int x, input int y, input int dir);
    drive_cmd(idx, x, y, dir);
    chk("cmd_ready_idle", 32'(cmd_ready_o), 32'd1);
    step();
    cmd_valid_i = 1'b0;
    model_cmd(idx, x, y, dir);
    check_objs("cmd");
  endtask

  task automatic do_reset();
    rst_i = 1'b1; cen_i = 1'b1; vh_blank_i = 2'b00; cmd_valid_i = 1'b0;
    step();
    chk("rst_done", 32'(update_done_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    step();
    model_reset();
    chk("rst_hcount", 32'(hcount_o), 32'd0);
    chk("rst_vcount", 32'(vcount_o), 32'd0);
    chk("rst_frame", 32'(frame_cnt_o), 32'd0);
    chk("rst_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_done2", 32'(update_done_o), 32'd0);
    check_objs("rst");
    rst_i = 1'b0;
  endtask

  // Vblank rise, optionally with a command in the same cycle; observe the sequence.
  task automatic run_frame(input bit with_cmd, input int idx, input int x, input int y,
                           input int dir, output int ndone);
    int nb, done_at;
    bit upd;
    vh_blank_i = 2'b10; cen_i = 1'b1;
    if (with_cmd) drive_cmd(idx, x, y, dir);
    step();
    cmd_valid_i = 1'b0; vh_blank_i = 2'b00;
    mframes++;
    if (with_cmd) model_cmd(idx, x, y, dir);
`ifdef OVL_SCHED_FRAME_DIV_EN
    upd = (mdiv == FRAME_DIV - 1);
    mdiv = upd ? 0 : mdiv + 1;
`else
    upd = 1'b1;
`endif
    if (upd) model_update();
    chk("vcount_vrise", 32'(vcount_o), 32'd0);
    chk("frame_cnt", 32'(frame_cnt_o), 32'(mframes & 16'hFFFF));
    chk("ready_after_vrise", 32'(cmd_ready_o), upd ? 32'd0 : 32'd1);
    nb = 0; ndone = 0; done_at = -1;
    for (int i = 0; i < 6; i++) begin
      nb += int'(busy_o);
      if (update_done_o) begin ndone++; done_at = i; end
      cen_i = 1'($urandom_range(0, 1));
      step();
    end
    cen_i = 1'b1;
    chk("busy_cycles", 32'(nb), upd ? 32'(N_OBJ + 1) : 32'd0);
    chk("done_pulses", 32'(ndone), upd ? 32'd1 : 32'd0);
    if (upd) chk("done_time", 32'(done_at), 32'(N_OBJ));
    check_objs("frame");
  endtask

  initial begin
    int nd, cnt, nupd;
    rst_i = 1'b1; cen_i = 1'b1; vh_blank_i = 2'b00; cmd_valid_i = 1'b0;
    cmd_idx_i = '0; cmd_x_i = '0; cmd_y_i = '0; cmd_dir_i = '0;
    do_reset();

    // Default objects after one update
    run_frame(0, 0, 0, 0, 0, nd);
    chk("first_x0", 32'(obj_x_o[11:0]), 32'd5);
    chk("first_y1", 32'(obj_y_o[23:12]), 32'd5);

    // Right edge bounce
    send_cmd(0, 1598, 100, 2'b01);
    run_frame(0, 0, 0, 0, 0, nd);
    chk("right_edge", 32'(obj_x_o[11:0]), 32'd1600);
    run_frame(0, 0, 0, 0, 0, nd);
    chk("right_back", 32'(obj_x_o[11:0]), 32'd1595);

    // Top edge bounce
    send_cmd(1, 700, 3, 2'b00);
    run_frame(0, 0, 0, 0, 0, nd);
    chk("top_edge", 32'(obj_y_o[23:12]), 32'd0);
    run_frame(0, 0, 0, 0, 0, nd);
    chk("top_back", 32'(obj_y_o[23:12]), 32'd5);

    // Clamp and out-of-range index
    send_cmd(0, 4000, 4000, 2'b11);
    chk("clamp_x", 32'(obj_x_o[11:0]), 32'd1600);
    send_cmd(5, 123, 456, 2'b10);

    // Command and vblank rise in the same cycle
    run_frame(1, 1, 10, 20, 2'b11, nd);
    chk("same_cycle_x1", 32'(obj_x_o[23:12]), 32'd15);

    // Randomized commands and frames
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 1) == 1)
        send_cmd($urandom_range(0, 7), $urandom_range(0, 4095), $urandom_range(0, 4095),
                 $urandom_range(0, 3));
      run_frame(1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2000),
                $urandom_range(0, 1200), $urandom_range(0, 3), nd);
    end

    // Raster counters over three lines
    run_frame(0, 0, 0, 0, 0, nd);
    for (int ln = 0; ln < 3; ln++) begin
      cen_i = 1'b1;
      vh_blank_i = 2'b01; step(); step();
      vh_blank_i = 2'b00; step();
      chk("hcount_fall", 32'(hcount_o), 32'd0);
      cnt = 0;
      for (int p = 0; p < 800; p++) begin
        cen_i = 1'($urandom_range(0, 3) != 0);
        step();
        if (cen_i) cnt++;
      end
      cen_i = 1'b1;
      chk("hcount_run", 32'(hcount_o), 32'(cnt));
      chk("vcount_line", 32'(vcount_o), 32'(ln + 1));
    end
    chk("vcount_three", 32'(vcount_o), 32'd3);
    run_frame(0, 0, 0, 0, 0, nd);

    // hcount saturation
    vh_blank_i = 2'b01; step();
    vh_blank_i = 2'b00; step();
    repeat (4100) step();
    chk("hcount_sat", 32'(hcount_o), 32'd4095);

    // Reset during the first update cycle
    vh_blank_i = 2'b10; cen_i = 1'b1; step();
    vh_blank_i = 2'b00;
    chk("mid_busy", 32'(busy_o), 32'd1);
    do_reset();

    // Four vblank rises after reset
    nupd = 0;
    for (int k = 0; k < 4; k++) begin
      run_frame(0, 0, 0, 0, 0, nd);
      nupd += nd;
    end
`ifdef OVL_SCHED_FRAME_DIV_EN
    chk("div_updates", 32'(nupd), 32'd2);
`else
    chk("div_updates", 32'(nupd), 32'd4);
`endif
    chk("div_frames", 32'(frame_cnt_o), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
